// File: rtl/branch_update_queue.sv
// Branch update queue: holds {pc_bits, prediction} for each in-flight predicted
// branch in fetch order. When the oldest branch resolves, it emits a registered
// predictor-update strobe one cycle later, with the outcome and a mispredict flag.
module branch_update_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 7,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [PC_W-1:0]  fetch_pc_bits,
    input  logic             fetch_prediction,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic             flush,
    output logic             upd_en,
    output logic [PC_W-1:0]  upd_pc_bits,
    output logic             upd_outcome,
    output logic             mispredict,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

    // Each entry is {pc_bits, prediction}; the prediction is in bit 0.
    logic [PC_W:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               upd_en_q, upd_en_d;
    logic [PC_W-1:0]    upd_pc_q, upd_pc_d;
    logic               upd_out_q, upd_out_d;
    logic               mispredict_q, mispredict_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               full_s;
    logic               empty_s;
    logic               pop_s;
    logic               push_s;
    logic [PC_W:0]      head_s;

    // Occupancy flags and the per-cycle push/pop decisions.
    always_comb begin
        full_s  = (count_q == DEPTH_C);
        empty_s = (count_q == CNT_ZERO);
        head_s  = mem_q[rd_ptr_q];
        // A resolve only consumes an entry that is already stored (no bypass).
        pop_s   = resolve_valid && !empty_s;
        // When full, a push needs the same-cycle pop to make room; a flush drops it.
        push_s  = fetch_valid && !flush && (!full_s || pop_s);
    end

    // Next state for pointers, count, sticky error flags and the update outputs.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        upd_en_d     = pop_s;
        upd_pc_d     = upd_pc_q;
        upd_out_d    = upd_out_q;
        mispredict_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (pop_s) begin
            upd_pc_d     = head_s[PC_W:1];
            upd_out_d    = resolve_taken;
            mispredict_d = (resolve_taken != head_s[0]);
        end else begin
            upd_pc_d     = upd_pc_q;
        end

        if (fetch_valid && full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        if (resolve_valid && empty_s) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_q;
        end

        // A flush lets the same-cycle pop report first, then empties the queue.
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= PTR_ZERO;
            rd_ptr_q     <= PTR_ZERO;
            count_q      <= CNT_ZERO;
            upd_en_q     <= 1'b0;
            upd_pc_q     <= {PC_W{1'b0}};
            upd_out_q    <= 1'b0;
            mispredict_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            upd_en_q     <= upd_en_d;
            upd_pc_q     <= upd_pc_d;
            upd_out_q    <= upd_out_d;
            mispredict_q <= mispredict_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Entry storage; written at the tail on an accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(PC_W + 1){1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {fetch_pc_bits, fetch_prediction};
        end
    end

    assign upd_en      = upd_en_q;
    assign upd_pc_bits = upd_pc_q;
    assign upd_outcome = upd_out_q;
    assign mispredict  = mispredict_q;
    assign count       = count_q;
    assign full        = full_s;
    assign empty       = empty_s;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Testbench for branch_update_queue: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_branch_update_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 7;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             fetch_valid;
    logic [PC_W-1:0]  fetch_pc_bits;
    logic             fetch_prediction;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             flush;
    logic             upd_en;
    logic [PC_W-1:0]  upd_pc_bits;
    logic             upd_outcome;
    logic             mispredict;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: queue of {pc, prediction} in arrival order.
    logic [PC_W:0]   mq[$];
    logic            m_upd_en;
    logic [PC_W-1:0] m_pc;
    logic            m_out;
    logic            m_mis;
    logic            m_ovf;
    logic            m_udf;

    branch_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_valid      (fetch_valid),
        .fetch_pc_bits    (fetch_pc_bits),
        .fetch_prediction (fetch_prediction),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .flush            (flush),
        .upd_en           (upd_en),
        .upd_pc_bits      (upd_pc_bits),
        .upd_outcome      (upd_outcome),
        .mispredict       (mispredict),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .overflow         (overflow),
        .underflow        (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all();
        chk("upd_en",      32'(upd_en),      32'(m_upd_en));
        chk("upd_pc_bits", 32'(upd_pc_bits), 32'(m_pc));
        chk("upd_outcome", 32'(upd_outcome), 32'(m_out));
        chk("mispredict",  32'(mispredict),  32'(m_mis));
        chk("count",       32'(count),       32'(mq.size()));
        chk("full",        32'(full),        32'(mq.size() == DEPTH));
        chk("empty",       32'(empty),       32'(mq.size() == 0));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("underflow",   32'(underflow),   32'(m_udf));
    endtask

    // Reference behaviour of one clock edge, from the queue's rules.
    task automatic model_edge(input logic fv, input logic [PC_W-1:0] pc, input logic pr,
                              input logic rv, input logic rt, input logic fl);
        int sz;
        logic pop;
        logic [PC_W:0] e;
        sz  = mq.size();
        pop = rv && (sz > 0);
        if (rv && sz == 0) m_udf = 1'b1;
        if (fv && sz == DEPTH && !pop) m_ovf = 1'b1;
        m_upd_en = pop;
        m_mis    = 1'b0;
        if (pop) begin
            e     = mq.pop_front();
            m_pc  = e[PC_W:1];
            m_out = rt;
            m_mis = (rt != e[0]);
        end
        if (fl) mq.delete();
        else if (fv && (sz < DEPTH || pop)) mq.push_back({pc, pr});
    endtask

    task automatic step(input logic fv, input logic [PC_W-1:0] pc, input logic pr,
                        input logic rv, input logic rt, input logic fl);
        fetch_valid      = fv;
        fetch_pc_bits    = pc;
        fetch_prediction = pr;
        resolve_valid    = rv;
        resolve_taken    = rt;
        flush            = fl;
        @(posedge clk);
        model_edge(fv, pc, pr, rv, rt, fl);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        fetch_valid      = 1'b0;
        fetch_pc_bits    = 7'h00;
        fetch_prediction = 1'b0;
        resolve_valid    = 1'b0;
        resolve_taken    = 1'b0;
        flush            = 1'b0;
    endtask

    // Asserts reset between clock edges, checks the reset values at once,
    // holds it across an edge and releases it on a falling edge.
    task automatic apply_reset();
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_count",      32'(count),       32'd0);
        chk("rst_empty",      32'(empty),       32'd1);
        chk("rst_full",       32'(full),        32'd0);
        chk("rst_upd_en",     32'(upd_en),      32'd0);
        chk("rst_upd_pc",     32'(upd_pc_bits), 32'd0);
        chk("rst_upd_out",    32'(upd_outcome), 32'd0);
        chk("rst_mispredict", 32'(mispredict),  32'd0);
        chk("rst_overflow",   32'(overflow),    32'd0);
        chk("rst_underflow",  32'(underflow),   32'd0);
        mq.delete();
        m_upd_en = 1'b0; m_pc = 7'h00; m_out = 1'b0; m_mis = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        mq.delete();
        m_upd_en = 1'b0; m_pc = 7'h00; m_out = 1'b0; m_mis = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        apply_reset();

        // Single mispredicted branch.
        step(1'b1, 7'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("s1_upd_en", 32'(upd_en),      32'd1);
        chk("s1_pc",     32'(upd_pc_bits), 32'h12);
        chk("s1_out",    32'(upd_outcome), 32'd0);
        chk("s1_mis",    32'(mispredict),  32'd1);
        chk("s1_count",  32'(count),       32'd0);
        chk("s1_empty",  32'(empty),       32'd1);
        step(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s1_upd_en_drop", 32'(upd_en), 32'd0);

        // Fill, overflow, drain in order.
        apply_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 7'(i), 1'(i % 2), 1'b0, 1'b0, 1'b0);
        step(1'b1, 7'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s2_full",  32'(full),     32'd1);
        chk("s2_ovf",   32'(overflow), 32'd1);
        chk("s2_count", 32'(count),    32'd4);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("s2_order", 32'(upd_pc_bits), 32'(i));
        end

        // Push and pop together while full.
        apply_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 7'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7'h09, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("s3_pc",    32'(upd_pc_bits), 32'd1);
        chk("s3_count", 32'(count),       32'd4);
        chk("s3_ovf",   32'(overflow),    32'd0);
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("s3_order", 32'(upd_pc_bits), 32'(i));
        end
        step(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("s3_last_pc", 32'(upd_pc_bits), 32'h09);
        chk("s3_last_mis", 32'(mispredict), 32'd0);

        // Flush with a same-cycle resolve and push.
        apply_reset();
        step(1'b1, 7'h21, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7'h23, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7'h2F, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("s4_upd_en", 32'(upd_en),      32'd1);
        chk("s4_pc",     32'(upd_pc_bits), 32'h21);
        chk("s4_mis",    32'(mispredict),  32'd1);
        chk("s4_count",  32'(count),       32'd0);
        chk("s4_empty",  32'(empty),       32'd1);
        step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("s4_no_upd", 32'(upd_en),    32'd0);
        chk("s4_udf",    32'(underflow), 32'd1);

        // Resolve on empty with a same-cycle push: no bypass.
        apply_reset();
        step(1'b1, 7'h05, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("s5_udf",    32'(underflow), 32'd1);
        chk("s5_upd_en", 32'(upd_en),    32'd0);
        chk("s5_count",  32'(count),     32'd1);
        step(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("s5_pc",     32'(upd_pc_bits), 32'h05);
        chk("s5_upd_en2", 32'(upd_en),     32'd1);

        // Asynchronous reset with entries queued and an update showing.
        apply_reset();
        step(1'b1, 7'h41, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7'h42, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7'h43, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("s6_pre_upd",   32'(upd_en), 32'd1);
        chk("s6_pre_count", 32'(count),  32'd2);
        apply_reset();
        step(1'b1, 7'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s6_first_push", 32'(count), 32'd1);
        chk("s6_no_upd",     32'(upd_en), 32'd0);
        step(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("s6_pc", 32'(upd_pc_bits), 32'h33);

        // Randomized traffic against the model.
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk);
                #1;
                apply_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom),
                     1'($urandom_range(0, 9) < 4), 1'($urandom),
                     1'($urandom_range(0, 19) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_update_queue.md
BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of in-flight predicted branches; legal values are powers of two, 2 or greater.
REQ-002 SHALL have parameter PC_W, default 7, meaning the width of the predictor-index PC bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port fetch_valid, input, 1 bit: a predicted branch enters this cycle.
REQ-006 SHALL have port fetch_pc_bits, input, PC_W bits: the branch PC index bits.
REQ-007 SHALL have port fetch_prediction, input, 1 bit: the predictor's taken/not-taken guess.
REQ-008 SHALL have port resolve_valid, input, 1 bit: the oldest outstanding branch resolves this cycle.
REQ-009 SHALL have port resolve_taken, input, 1 bit: the actual outcome.
REQ-010 SHALL have port flush, input, 1 bit: discard all queued entries.
REQ-011 SHALL have port upd_en, output, 1 bit: predictor update strobe.
REQ-012 SHALL have port upd_pc_bits, output, PC_W bits: the PC bits of the resolved entry.
REQ-013 SHALL have port upd_outcome, output, 1 bit: the resolved outcome.
REQ-014 SHALL have port mispredict, output, 1 bit: the resolved outcome differed from the stored prediction.
REQ-015 SHALL have port count, output, clog2(DEPTH+1) bits: the number of occupied entries.
REQ-016 SHALL have ports full and empty, output, 1 bit each: occupancy flags.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag, push attempted while full.
REQ-018 SHALL have port underflow, output, 1 bit: sticky flag, resolve attempted while empty.

Function
REQ-019 SHALL implement a circular FIFO of DEPTH entries, each holding {pc_bits, prediction}, with read/write pointers that wrap modulo DEPTH.
REQ-020 SHALL accept a push when fetch_valid=1 and either count<DEPTH, or count=DEPTH with a legal pop in the same cycle.
REQ-021 SHALL treat a pop as legal when resolve_valid=1 and count>0; the head entry is consumed.
REQ-022 SHALL, one cycle after a legal pop, drive upd_en=1, upd_pc_bits=head pc_bits, upd_outcome=resolve_taken, and mispredict=(resolve_taken != head prediction), all registered.
REQ-023 SHALL hold upd_en and mispredict at 0 in every cycle not following a legal pop; upd_pc_bits and upd_outcome hold their last values.
REQ-024 SHALL have no bypass: a push and a resolve in the same cycle on an empty queue is a push plus an underflow, and produces no update.
REQ-025 SHALL ignore a push while full with no pop, leave the queue unchanged, and set overflow.
REQ-026 SHALL ignore a resolve while empty, produce no update, and set underflow.
REQ-027 SHALL keep overflow and underflow set until reset.
REQ-028 SHALL, on flush=1, first process a same-cycle legal pop per REQ-022, then clear all entries (count=0), and ignore any same-cycle push.
REQ-029 SHALL update count as count + push - pop per cycle, never exceeding DEPTH or going below 0.
REQ-030 SHALL drive full=(count==DEPTH) and empty=(count==0) combinationally from the registered count.

Reset
REQ-031 SHALL, while reset=0 and regardless of clk, set pointers=0, count=0, empty=1, full=0, upd_en=0, upd_pc_bits=0, upd_outcome=0, mispredict=0, overflow=0, underflow=0.
REQ-032 SHALL, when reset asserts mid-operation, discard all entries and cancel any pending update.
REQ-033 SHALL accept a push on the first rising edge after reset deasserts.

Verification
REQ-034 Bench SHALL check this scenario: push pc=0x12 with pred=1, then resolve taken=0 -> next cycle upd_en=1, upd_pc_bits=0x12, upd_outcome=0, mispredict=1, count=0, empty=1.
REQ-035 Bench SHALL check this scenario: 4 pushes (pc 1..4), then a 5th push -> full=1, overflow=1, count=4; 4 resolves then return pcs 1,2,3,4 in order.
REQ-036 Bench SHALL check this scenario: full queue with simultaneous push pc=9 and resolve -> update for pc 1, count stays 4, overflow=0, pc 9 returned last after 3 more resolves.
REQ-037 Bench SHALL check this scenario: 3 entries queued, flush together with resolve -> one update for the head entry, count=0, empty=1, and a same-cycle push is dropped.
REQ-038 Bench SHALL check this scenario: resolve on an empty queue with a same-cycle push pc=5 -> underflow=1, upd_en=0, count=1, and a later resolve returns pc 5.
REQ-039 Bench SHALL check this scenario: assert reset asynchronously between clock edges with 2 entries queued -> all outputs take the REQ-031 values immediately, and no update follows.
